dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder: the slave end of the CPU data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake, inserts a programmable number of wait states, then returns a registered response.
- Sits between the core's load/store datapath and a 4 KB word array.
- Lets the core be exercised against a memory that does not answer in the same cycle.

Parameters:
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W words of 32 bits (4 KB default).
- LATENCY, 2, wait-state cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i writes byte i (bits 8i+7:8i).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE; req_ready=0 during the reset cycle and 1 on the first cycle after.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All memory words are cleared to 0.
  - Reset mid-transaction aborts it; a captured but not yet committed store is discarded.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/wdata/be. Go to WAIT with counter=LATENCY-1, or straight to RESP when LATENCY=0.
  - WAIT: req_ready=0. Decrement counter each cycle. When counter=0, commit the access and go to RESP.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err stable until handshake. On rsp_ready, go to IDLE the next cycle.
- Latency:
  - Request accepted at edge t drives rsp_valid=1 from cycle t+LATENCY+1.
  - With rsp_ready tied 1, the minimum request-to-request spacing is LATENCY+2 cycles.
  - No back-to-back acceptance: req_ready=0 in the cycle of the response handshake.
- Commit (single edge, entering RESP):
  - Load: rsp_rdata = mem[addr[ADDR_W+1:2]].
  - Store: update only enabled bytes; rsp_rdata=0. req_be=4'b0000 is a legal no-op store with rsp_err=0.
- Error rule: rsp_err=1 if addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
  - On error: no memory write, rsp_rdata=0, still completes normally through WAIT/RESP with the same latency.
- Inputs sampled only at acceptance; changes to req_* while in WAIT/RESP are ignored.
- Backpressure: rsp_ready=0 holds RESP indefinitely; outputs must not change.
- Load after store to the same address returns the new data, since the commit is completed before the next acceptance.
- Outputs are registered; no combinational path from req_* to rsp_*. req_ready is a decode of the state register only.

Decomposition:
- Shared package dm_pkg:
  - FSM state enum (IDLE, WAIT, RESP).
  - Byte-enable constants BE_WORD=4'b1111, BE_NONE=4'b0000.
  - Default ADDR_W.
- One natural sub-module: dm_word_ram.
  - Synchronous word array with per-byte write enable and synchronous clear.
  - dm_responder holds the FSM, capture registers, wait counter and error check.

Test Plan:
- Reset then idle: assert rst 2 cycles -> req_ready=1 the cycle after release; rsp_valid=0; load from 0x0 returns rsp_rdata=0x00000000, rsp_err=0.
- Store/load, LATENCY=2: store 0xDEADBEEF to 0x10 with be=1111 accepted at cycle t -> rsp_valid at t+3, rsp_rdata=0; load 0x10 -> rsp_rdata=0xDEADBEEF at acceptance+3.
- Partial store: word at 0x20 = 0x11223344; store 0xAABBCCDD be=0101 -> load 0x20 returns 0x11BB33DD.
- Errors: load 0x13 -> rsp_err=1, rsp_rdata=0. Store to 0x1000 (ADDR_W=10) -> rsp_err=1, and word 0 is unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP while toggling req_valid/req_addr -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0. Release -> IDLE the next cycle.
- Reset mid-operation and LATENCY=0: with LATENCY=0, the response arrives 1 cycle after acceptance. With LATENCY=3, assert rst during WAIT of a store to 0x40 -> rsp_valid never asserts and a later load of 0x40 returns 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmState_e;

  localparam logic [3:0] BE_WORD   = 4'b1111;
  localparam logic [3:0] BE_NONE   = 4'b0000;
  localparam int         DM_ADDR_W = 10;

  // A byte address is bad when it is not word aligned or lies beyond the array.
  function automatic logic addrIsBad(input logic [31:0] addr, input int addrW);
    logic [31:0] hiMask;
    hiMask = 32'hFFFF_FFFF << (addrW + 2);
    return (addr[1:0] != 2'b00) || ((addr & hiMask) != 32'd0);
  endfunction

endpackage

// File: rtl/dm_word_ram.sv
// Word array split into four byte lanes, each with its own write enable,
// synchronous clear and registered read port.
module dm_word_ram
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [3:0]        wbe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              rdEn,
  input  logic              rdZero,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gLane
      logic [7:0] laneMem [DEPTH];
      logic [7:0] laneRdReg;

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) begin
            laneMem[i] <= 8'h00;
          end
          laneRdReg <= 8'h00;
        end else begin
          if (wbe[gi]) begin
            laneMem[addr] <= wdata[8*gi +: 8];
          end
          // rdZero wins so stores and errors present an all-zero response word
          if (rdZero) begin
            laneRdReg <= 8'h00;
          end else if (rdEn) begin
            laneRdReg <= laneMem[addr];
          end
        end
      end

      assign rdata[8*gi +: 8] = laneRdReg;
    end
  endgenerate

endmodule

// File: rtl/dm_responder.sv
// Slave end of the CPU data-memory port: one request at a time, LATENCY wait
// states, then a registered response held until the core takes it.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = DM_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  dmState_e    stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        readyReg;
  logic        errReg;
  logic        weReg;
  logic [31:0] addrReg, wdataReg;
  logic [3:0]  beReg;

  logic        accept, commit;
  logic        cWe, cErr;
  logic [31:0] cAddr, cWdata;
  logic [3:0]  cBe;
  logic [3:0]  ramWbe;

  assign accept = req_valid && readyReg;

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    commit    = 1'b0;
    cWe       = weReg;
    cAddr     = addrReg;
    cWdata    = wdataReg;
    cBe       = beReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            // zero wait states: commit straight from the request inputs
            stateNext = RESP;
            commit    = 1'b1;
            cWe       = req_we;
            cAddr     = req_addr;
            cWdata    = req_wdata;
            cBe       = req_be;
          end else begin
            stateNext = WAIT;
            cntNext   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cntReg == 4'd0) begin
          stateNext = RESP;
          commit    = 1'b1;
        end else begin
          cntNext = cntReg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign cErr   = addrIsBad(cAddr, ADDR_W);
  assign ramWbe = (commit && cWe && !cErr) ? (cBe & BE_WORD) : BE_NONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg <= IDLE;
      cntReg   <= 4'd0;
      readyReg <= 1'b0;
      errReg   <= 1'b0;
      weReg    <= 1'b0;
      addrReg  <= 32'd0;
      wdataReg <= 32'd0;
      beReg    <= 4'd0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      // ready tracks IDLE but stays low for the first cycle out of reset
      readyReg <= (stateNext == IDLE);
      if (accept) begin
        weReg    <= req_we;
        addrReg  <= req_addr;
        wdataReg <= req_wdata;
        beReg    <= req_be;
      end
      if (commit) begin
        errReg <= cErr;
      end
    end
  end

  dm_word_ram #(
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk   (clk),
    .clr   (rst),
    .wbe   (ramWbe),
    .addr  (cAddr[ADDR_W+1:2]),
    .wdata (cWdata),
    .rdEn  (commit),
    .rdZero(commit && (cWe || cErr)),
    .rdata (rsp_rdata)
  );

  assign req_ready = readyReg;
  assign rsp_valid = (stateReg == RESP);
  assign rsp_err   = errReg;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 0, 3) checked against a
// word-array model built from the load/store/error rules.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reqValid, reqReady, reqWe, rspValid, rspReady, rspErr;
  logic [31:0] reqAddr [3];
  logic [31:0] reqWdata [3];
  logic [31:0] rspRdata [3];
  logic [3:0]  reqBe [3];

  logic [31:0] model [3][1024];
  int          lat [3] = '{2, 0, 3};
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_W(10), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
    .req_we(reqWe[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );
  dm_responder #(.ADDR_W(10), .LATENCY(0)) u1 (
    .clk(clk), .rst(rst), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
    .req_we(reqWe[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );
  dm_responder #(.ADDR_W(10), .LATENCY(3)) u2 (
    .clk(clk), .rst(rst), .req_valid(reqValid[2]), .req_ready(reqReady[2]),
    .req_we(reqWe[2]), .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]), .req_be(reqBe[2]),
    .rsp_valid(rspValid[2]), .rsp_ready(rspReady[2]), .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2])
  );

  task automatic clearModel();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 1024; i++) model[d][i] = 32'd0;
  endtask

  // One full transaction on instance d, with bp cycles of response backpressure.
  task automatic doTxn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int bp);
    logic        expErr;
    logic [31:0] expData;
    int          idx;
    int          n;
    expErr  = (addr % 4 != 0) || (addr >= 32'd4096);
    expData = 32'd0;
    if (!expErr) begin
      idx = int'(addr >> 2);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        expData = model[d][idx];
      end
    end

    n = 0;
    while (reqReady[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (reqReady[d] !== 1'b1) begin
      $display("FAIL ready_timeout dut%0d got %b want 1", d, reqReady[d]);
      errors++;
      return;
    end

    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqBe[d]    = be;
    @(negedge clk);
    // scramble the request bus; it must be ignored from here on
    reqValid[d] = 1'($urandom_range(0, 1));
    reqWe[d]    = 1'($urandom_range(0, 1));
    reqAddr[d]  = $urandom;
    reqWdata[d] = $urandom;
    reqBe[d]    = 4'($urandom_range(0, 15));

    n = 0;
    while (rspValid[d] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      reqValid[d] = 1'($urandom_range(0, 1));
      reqAddr[d]  = $urandom;
    end
    checks++;
    if (n !== lat[d]) begin
      $display("FAIL latency dut%0d got %0d edges want %0d", d, n, lat[d]);
      errors++;
    end
    if (rspValid[d] !== 1'b1) return;

    checks++;
    if (rspRdata[d] !== expData || reqReady[d] !== 1'b0) begin
      $display("FAIL rsp_rdata dut%0d addr=%h got %h ready=%b want %h ready=0",
               d, addr, rspRdata[d], reqReady[d], expData);
      errors++;
    end
    checks++;
    if (rspErr[d] !== expErr) begin
      $display("FAIL rsp_err dut%0d addr=%h got %b want %b", d, addr, rspErr[d], expErr);
      errors++;
    end

    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      reqValid[d] = 1'($urandom_range(0, 1));
      reqAddr[d]  = $urandom;
      checks++;
      if (rspValid[d] !== 1'b1 || reqReady[d] !== 1'b0 || rspErr[d] !== expErr ||
          rspRdata[d] !== expData) begin
        $display("FAIL backpressure dut%0d cyc%0d got v=%b r=%b e=%b d=%h want v=1 r=0 e=%b d=%h",
                 d, i, rspValid[d], reqReady[d], rspErr[d], rspRdata[d], expErr, expData);
        errors++;
      end
    end

    reqValid[d] = 1'b0;
    rspReady[d] = 1'b1;
    @(negedge clk);
    rspReady[d] = 1'b0;
    checks++;
    if (rspValid[d] !== 1'b0 || reqReady[d] !== 1'b1) begin
      $display("FAIL return_idle dut%0d got v=%b r=%b want v=0 r=1", d, rspValid[d], reqReady[d]);
      errors++;
    end
    $display("TXN dut%0d %s addr=%h wdata=%h be=%b -> rdata=%h err=%b lat=%0d",
             d, we ? "ST" : "LD", addr, wdata, be, expData, expErr, n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (reqReady[d] !== 1'b0 || rspValid[d] !== 1'b0 || rspErr[d] !== 1'b0 ||
          rspRdata[d] !== 32'd0) begin
        $display("FAIL reset_state dut%0d got r=%b v=%b e=%b d=%h want 0 0 0 0",
                 d, reqReady[d], rspValid[d], rspErr[d], rspRdata[d]);
        errors++;
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (reqReady[d] !== 1'b1 || rspValid[d] !== 1'b0) begin
        $display("FAIL ready_after_reset dut%0d got r=%b v=%b want r=1 v=0",
                 d, reqReady[d], rspValid[d]);
        errors++;
      end
    end
    clearModel();
    doTxn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  task automatic test_store_load();
    doTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
    doTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_partial();
    doTxn(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 0);
    doTxn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    doTxn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    doTxn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0);
    doTxn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);
  endtask

  task automatic test_errors();
    doTxn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
    doTxn(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'b1111, 0);
    doTxn(0, 1'b1, 32'h1000, 32'h12345678, 4'b1111, 0);
    doTxn(0, 1'b1, 32'h2, 32'h87654321, 4'b1111, 0);
    doTxn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
  endtask

  task automatic test_backpressure();
    doTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    doTxn(2, 1'b0, 32'h44, 32'h0, 4'h0, 5);
  endtask

  task automatic test_latency0();
    doTxn(1, 1'b1, 32'h8, 32'hC0FFEE01, 4'b1111, 0);
    doTxn(1, 1'b0, 32'h8, 32'h0, 4'h0, 0);
    doTxn(1, 1'b0, 32'h9, 32'h0, 4'h0, 2);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (reqReady[2] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    reqValid[2] = 1'b1;
    reqWe[2]    = 1'b1;
    reqAddr[2]  = 32'h40;
    reqWdata[2] = 32'hCAFEF00D;
    reqBe[2]    = 4'b1111;
    @(negedge clk);
    reqValid[2] = 1'b0;
    checks++;
    if (rspValid[2] !== 1'b0 || reqReady[2] !== 1'b0) begin
      $display("FAIL mid_wait dut2 got v=%b r=%b want v=0 r=0", rspValid[2], reqReady[2]);
      errors++;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (rspValid[2] !== 1'b0) begin
        $display("FAIL aborted_rsp dut2 cyc%0d got v=%b want 0", i, rspValid[2]);
        errors++;
      end
    end
    doTxn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0);
    doTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
  endtask

  task automatic test_random();
    int          d;
    logic [31:0] addr;
    for (int t = 0; t < 60; t++) begin
      d    = $urandom_range(0, 2);
      addr = 32'($urandom_range(0, 15)) * 4;
      case ($urandom_range(0, 7))
        0: addr = addr + 32'($urandom_range(1, 3));
        1: addr = addr | (32'h1000 << $urandom_range(0, 19));
        default: ;
      endcase
      doTxn(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst      = 1'b1;
    reqValid = '0;
    reqWe    = '0;
    rspReady = '0;
    for (int d = 0; d < 3; d++) begin
      reqAddr[d]  = 32'd0;
      reqWdata[d] = 32'd0;
      reqBe[d]    = 4'd0;
    end
    test_reset();
    test_store_load();
    test_partial();
    test_errors();
    test_backpressure();
    test_latency0();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
